// File: rtl/divisor_unit_pkg.sv
// Shared types and sizing helpers for the iterative divider.
// State encoding and step-counter width live here so top and bench agree.
package divisor_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    function automatic int cnt_width(input int p);
        return $clog2(p + 1);
    endfunction

endpackage

// File: rtl/divisor_unit_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, keep or restore.
module divisor_unit_step #(
    parameter int parallelism = 32
) (
    input  logic [parallelism-1:0] i_rem,
    input  logic                   i_dvd_bit,
    input  logic [parallelism-1:0] i_divisor,
    output logic [parallelism-1:0] o_rem,
    output logic                   o_q_bit
);

    logic [parallelism:0] w_shifted;
    logic [parallelism:0] w_diff;

    // The partial remainder stays below the divisor, so the MSB of an
    // (N+1)-bit difference is a reliable borrow/sign flag.
    assign w_shifted = {i_rem, i_dvd_bit};
    assign w_diff    = w_shifted - {1'b0, i_divisor};
    assign o_q_bit   = ~w_diff[parallelism];
    assign o_rem     = o_q_bit ? w_diff[parallelism-1:0] : w_shifted[parallelism-1:0];

endmodule

// File: rtl/divisor_unit.sv
// Iterative signed/unsigned divider with RISC-V DIV/REM result semantics.
// Optional DIVISOR_UNIT_EARLY_OUT_EN: divide-by-zero and signed overflow skip BUSY.
//   state | meaning
//   IDLE  | waiting for valid, latches operand magnitudes and sign flags
//   BUSY  | one restoring step per cycle, parallelism cycles
//   FIX   | sign correction and special cases, loads result registers
//   DONE  | res_ready strobe for one cycle
module divisor_unit
    import divisor_unit_pkg::*;
#(
    parameter int parallelism = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid,
    input  logic                   usigned,
    input  logic [parallelism-1:0] dividend,
    input  logic [parallelism-1:0] divisor,
    output logic [parallelism-1:0] quotient,
    output logic [parallelism-1:0] reminder,
    output logic                   res_ready
);

    localparam int                    CW        = cnt_width(parallelism);
    localparam logic [CW-1:0]         LAST_STEP = CW'(parallelism - 1);
    localparam logic [parallelism-1:0] MOST_NEG = {1'b1, {(parallelism-1){1'b0}}};

    div_state_t               r_state, w_state_next;
    logic [CW-1:0]            r_cnt;
    logic [parallelism-1:0]   r_rem, r_dvd, r_dvs, r_orig;
    logic [parallelism-1:0]   r_quotient, r_reminder;
    logic                     r_neg_q, r_neg_r, r_div_zero, r_ovf;

    logic                     w_dvd_neg, w_dvs_neg, w_div_zero_in, w_ovf_in;
    logic [parallelism-1:0]   w_dvd_mag, w_dvs_mag;
    logic [parallelism-1:0]   w_step_rem, w_q_fix, w_r_fix;
    logic                     w_step_q;

    assign w_dvd_neg     = ~usigned & dividend[parallelism-1];
    assign w_dvs_neg     = ~usigned & divisor[parallelism-1];
    assign w_dvd_mag     = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag     = w_dvs_neg ? -divisor : divisor;
    assign w_div_zero_in = (divisor == '0);
    assign w_ovf_in      = ~usigned & (dividend == MOST_NEG) & (divisor == '1);

    divisor_unit_step #(.parallelism(parallelism)) u_step (
        .i_rem     (r_rem),
        .i_dvd_bit (r_dvd[parallelism-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_step_rem),
        .o_q_bit   (w_step_q)
    );

    always_comb begin
        w_q_fix = r_neg_q ? -r_dvd : r_dvd;
        w_r_fix = r_neg_r ? -r_rem : r_rem;
        if (r_div_zero) begin
            w_q_fix = '1;
            w_r_fix = r_orig;
        end else if (r_ovf) begin
            w_q_fix = MOST_NEG;
            w_r_fix = '0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (valid) begin
`ifdef DIVISOR_UNIT_EARLY_OUT_EN
                    w_state_next = (w_div_zero_in | w_ovf_in) ? FIX : BUSY;
`else
                    w_state_next = BUSY;
`endif
                end
            end
            BUSY:    if (r_cnt == LAST_STEP) w_state_next = FIX;
            FIX:     w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_orig     <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
            r_quotient <= '0;
            r_reminder <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (valid) begin
                        r_cnt      <= '0;
                        r_rem      <= '0;
                        r_dvd      <= w_dvd_mag;
                        r_dvs      <= w_dvs_mag;
                        r_orig     <= dividend;
                        r_neg_q    <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r    <= w_dvd_neg;
                        r_div_zero <= w_div_zero_in;
                        r_ovf      <= w_ovf_in;
                    end
                end
                BUSY: begin
                    // r_dvd doubles as the quotient shift register.
                    r_rem <= w_step_rem;
                    r_dvd <= {r_dvd[parallelism-2:0], w_step_q};
                    r_cnt <= r_cnt + CW'(1);
                end
                FIX: begin
                    r_quotient <= w_q_fix;
                    r_reminder <= w_r_fix;
                end
                default: ;
            endcase
        end
    end

    assign quotient  = r_quotient;
    assign reminder  = r_reminder;
    assign res_ready = (r_state == DONE);

endmodule

// File: tb/tb_divisor_unit.sv
// Directed self-checking bench for divisor_unit (width 32), both early-out builds.
module tb_divisor_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic        usigned;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] reminder;
    logic        res_ready;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_q = 32'h0;
    logic [31:0] last_r = 32'h0;

    // Edges counted after the acceptance edge until res_ready is seen high.
    localparam int LAT_FULL = 33;
`ifdef DIVISOR_UNIT_EARLY_OUT_EN
    localparam int LAT_SPEC = 1;
`else
    localparam int LAT_SPEC = 33;
`endif

    divisor_unit #(.parallelism(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (valid),
        .usigned   (usigned),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .reminder  (reminder),
        .res_ready (res_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic us, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_q,
                          input logic [31:0] exp_r, input int exp_lat);
        int n;
        @(negedge clk);
        usigned  = us;
        dividend = a;
        divisor  = b;
        valid    = 1'b1;
        @(posedge clk);
        #1;
        valid    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        usigned  = ~us;
        chk({tag, " hold_q"}, quotient, last_q);
        n = 0;
        while (!res_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " ready"}, {31'b0, res_ready}, 32'h1);
        chk({tag, " latency"}, 32'(n), 32'(exp_lat));
        chk({tag, " q"}, quotient, exp_q);
        chk({tag, " r"}, reminder, exp_r);
        @(posedge clk);
        #1;
        chk({tag, " pulse"}, {31'b0, res_ready}, 32'h0);
        chk({tag, " stable_q"}, quotient, exp_q);
        last_q = exp_q;
        last_r = exp_r;
    endtask

    initial begin
        int pulses;
        int pos [3];
        int saw;

        rst_n    = 1'b0;
        valid    = 1'b0;
        usigned  = 1'b0;
        dividend = 32'h0;
        divisor  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset q", quotient, 32'h0);
        chk("reset r", reminder, 32'h0);
        chk("reset ready", {31'b0, res_ready}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("signed",      1'b0, 32'hFFFFFF8B, 32'h0000000A, 32'hFFFFFFF5, 32'hFFFFFFF9, LAT_FULL);
        run_op("unsigned",    1'b1, 32'hFFFFFF8B, 32'h0000000A, 32'h1999998D, 32'h00000009, LAT_FULL);
        run_op("divz_s",      1'b0, 32'h00000064, 32'h00000000, 32'hFFFFFFFF, 32'h00000064, LAT_SPEC);
        run_op("divz_u",      1'b1, 32'h00000064, 32'h00000000, 32'hFFFFFFFF, 32'h00000064, LAT_SPEC);
        run_op("divz_neg",    1'b0, 32'hFFFFFF8B, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFF8B, LAT_SPEC);
        run_op("ovf",         1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, LAT_SPEC);
        run_op("ovf_u",       1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, LAT_FULL);
        run_op("p7_m2",       1'b0, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, LAT_FULL);
        run_op("m7_m2",       1'b0, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, LAT_FULL);
        run_op("m8_p2",       1'b0, 32'hFFFFFFF8, 32'h00000002, 32'hFFFFFFFC, 32'h00000000, LAT_FULL);
        run_op("zero_num",    1'b0, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, LAT_FULL);
        run_op("max_u_div1",  1'b1, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, LAT_FULL);
        run_op("mostneg_s2",  1'b0, 32'h80000000, 32'h00000002, 32'hC0000000, 32'h00000000, LAT_FULL);

        // valid held high: pulses every parallelism+3 edges, first one LAT_FULL after acceptance.
        @(negedge clk);
        usigned  = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd7;
        valid    = 1'b1;
        pulses = 0;
        for (int i = 0; i < 110; i++) begin
            @(posedge clk);
            #1;
            if (res_ready) begin
                if (pulses < 3) pos[pulses] = i;
                pulses++;
                chk("b2b q", quotient, 32'd142);
                chk("b2b r", reminder, 32'd6);
            end
        end
        valid = 1'b0;
        chk("b2b pulses", 32'(pulses), 32'd3);
        if (pulses >= 3) begin
            chk("b2b pos0", 32'(pos[0]), 32'd33);
            chk("b2b pos1", 32'(pos[1]), 32'd68);
            chk("b2b pos2", 32'(pos[2]), 32'd103);
        end
        repeat (40) @(posedge clk);
        #1;
        last_q = 32'd142;
        last_r = 32'd6;

        // Reset in BUSY cycle 10 discards the operation.
        @(negedge clk);
        usigned  = 1'b0;
        dividend = 32'd500;
        divisor  = 32'd3;
        valid    = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst q", quotient, 32'h0);
        chk("midrst r", reminder, 32'h0);
        chk("midrst ready", {31'b0, res_ready}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (res_ready) saw++;
        end
        chk("midrst no_ready", 32'(saw), 32'd0);
        last_q = 32'h0;
        last_r = 32'h0;

        run_op("after_rst", 1'b0, 32'd500, 32'd3, 32'd166, 32'd2, LAT_FULL);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
